// File: rtl/decode_buffer.sv
// Instruction decode queue: multi-lane MIPS32 decode on enqueue into a circular
// buffer, presenting the oldest entries to issue each cycle.
package decode_buffer_pkg;
    typedef enum logic [6:0] {
        NOP, SLL, SRL, SRA, SLLV, SRLV, SRAV,
        JR, JALR, SYSCALL, BREAK,
        MFHI, MTHI, MFLO, MTLO,
        MULT, MULTU, DIV, DIVU,
        ADD, ADDU, SUB, SUBU,
        AND, OR, XOR, NOR, SLT, SLTU,
        BLTZ, BGEZ, BLTZAL, BGEZAL,
        J, JAL, BEQ, BNE, BLEZ, BGTZ,
        ADDI, ADDIU, SLTI, SLTIU,
        ANDI, ORI, XORI, LUI,
        MFC0, MTC0, ERET,
        MADD, MADDU, MSUB, MSUBU,
        MUL, CLZ, CLO,
        LB, LH, LWL, LW, LBU, LHU, LWR,
        SB, SH, SWL, SW, SWR,
        DECODE_ERROR
    } op_t;
endpackage

module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int FETCH_W     = 2,
    parameter int ISSUE_W     = 2,
    parameter int DEPTH       = 8,
    parameter int EN_SPECIAL2 = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [$clog2(FETCH_W+1)-1:0] in_cnt,
    input  logic [FETCH_W*32-1:0]        in_instr,
    input  logic [FETCH_W*32-1:0]        in_pc,
    output logic                         in_ready,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [ISSUE_W*32-1:0]        out_instr,
    output logic [ISSUE_W*32-1:0]        out_pc,
    output op_t                          out_op [ISSUE_W],
    output logic [ISSUE_W-1:0]           out_ri,
    input  logic [$clog2(ISSUE_W+1)-1:0] out_take,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [OW-1:0]    r_occ;
    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_pc    [DEPTH];
    op_t              r_op    [DEPTH];
    logic [DEPTH-1:0] r_ri;

    op_t              w_dec_op [FETCH_W];
    logic [FETCH_W-1:0] w_dec_ri;
    logic             w_enq;
    logic [OW-1:0]    w_enq_cnt;
    logic [OW-1:0]    w_take;

    function automatic op_t f_decode(input logic [31:0] ins);
        logic [5:0] opc;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        op_t        op;
        opc = ins[31:26];
        fn  = ins[5:0];
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        op  = DECODE_ERROR;
        unique case (opc)
            6'b000000: begin
                unique case (fn)
                    6'h00:   op = (rd == 5'd0) ? NOP : SLL;
                    6'h02:   op = SRL;
                    6'h03:   op = SRA;
                    6'h04:   op = SLLV;
                    6'h06:   op = SRLV;
                    6'h07:   op = SRAV;
                    6'h08:   op = JR;
                    6'h09:   op = JALR;
                    6'h0c:   op = SYSCALL;
                    6'h0d:   op = BREAK;
                    6'h10:   op = MFHI;
                    6'h11:   op = MTHI;
                    6'h12:   op = MFLO;
                    6'h13:   op = MTLO;
                    6'h18:   op = MULT;
                    6'h19:   op = MULTU;
                    6'h1a:   op = DIV;
                    6'h1b:   op = DIVU;
                    6'h20:   op = ADD;
                    6'h21:   op = ADDU;
                    6'h22:   op = SUB;
                    6'h23:   op = SUBU;
                    6'h24:   op = AND;
                    6'h25:   op = OR;
                    6'h26:   op = XOR;
                    6'h27:   op = NOR;
                    6'h2a:   op = SLT;
                    6'h2b:   op = SLTU;
                    default: op = DECODE_ERROR;
                endcase
            end
            6'b000001: begin
                unique case (rt)
                    5'b00000: op = BLTZ;
                    5'b00001: op = BGEZ;
                    5'b10000: op = BLTZAL;
                    5'b10001: op = BGEZAL;
                    default:  op = DECODE_ERROR;
                endcase
            end
            6'b000010: op = J;
            6'b000011: op = JAL;
            6'b000100: op = BEQ;
            6'b000101: op = BNE;
            6'b000110: op = BLEZ;
            6'b000111: op = BGTZ;
            6'b001000: op = ADDI;
            6'b001001: op = ADDIU;
            6'b001010: op = SLTI;
            6'b001011: op = SLTIU;
            6'b001100: op = ANDI;
            6'b001101: op = ORI;
            6'b001110: op = XORI;
            6'b001111: op = LUI;
            6'b010000: begin
                if (rs == 5'b00000)
                    op = MFC0;
                else if (rs == 5'b00100)
                    op = MTC0;
                else if (ins[25] && ins[24:6] == '0)
                    op = ERET;
            end
            6'b011100: begin
                // SPECIAL2 is optional; cores without it trap as reserved
                if (EN_SPECIAL2 != 0) begin
                    unique case (fn)
                        6'b000000: op = MADD;
                        6'b000001: op = MADDU;
                        6'b000100: op = MSUB;
                        6'b000101: op = MSUBU;
                        6'b000010: op = MUL;
                        6'b100000: op = CLZ;
                        6'b100001: op = CLO;
                        default:   op = DECODE_ERROR;
                    endcase
                end
            end
            6'b100000: op = LB;
            6'b100001: op = LH;
            6'b100010: op = LWL;
            6'b100011: op = LW;
            6'b100100: op = LBU;
            6'b100101: op = LHU;
            6'b100110: op = LWR;
            6'b101000: op = SB;
            6'b101001: op = SH;
            6'b101010: op = SWL;
            6'b101011: op = SW;
            6'b101110: op = SWR;
            default:   op = DECODE_ERROR;
        endcase
        return op;
    endfunction

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            w_dec_op[i] = f_decode(in_instr[32*i +: 32]);
            w_dec_ri[i] = (w_dec_op[i] == DECODE_ERROR);
        end
    end

    // Space check uses pre-dequeue occupancy so issue never gates fetch
    assign in_ready = (32'(r_occ) + FETCH_W) <= DEPTH;
    assign w_enq    = in_ready && (in_cnt != '0) && !flush;

    always_comb begin
        w_enq_cnt = '0;
        if (w_enq) begin
            if (32'(in_cnt) > FETCH_W)
                w_enq_cnt = OW'(FETCH_W);
            else
                w_enq_cnt = OW'(in_cnt);
        end
    end

    always_comb begin
        w_take = OW'(out_take);
        if (32'(w_take) > ISSUE_W)
            w_take = OW'(ISSUE_W);
        if (w_take > r_occ)
            w_take = r_occ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + PW'(w_take);
            r_tail <= r_tail + PW'(w_enq_cnt);
            r_occ  <= r_occ + w_enq_cnt - w_take;
        end
    end

    // Payload needs no reset: visibility is governed by r_occ alone
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (i < 32'(w_enq_cnt)) begin
                r_instr[r_tail + PW'(i)] <= in_instr[32*i +: 32];
                r_pc[r_tail + PW'(i)]    <= in_pc[32*i +: 32];
                r_op[r_tail + PW'(i)]    <= w_dec_op[i];
                r_ri[r_tail + PW'(i)]    <= w_dec_ri[i];
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_ri    = '0;
        out_instr = '0;
        out_pc    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i]       = 32'(r_occ) > i;
            out_instr[32*i +: 32] = r_instr[r_head + PW'(i)];
            out_pc[32*i +: 32] = r_pc[r_head + PW'(i)];
            out_op[i]          = r_op[r_head + PW'(i)];
            out_ri[i]          = (32'(r_occ) > i) && r_ri[r_head + PW'(i)];
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer: decode, handshakes, wrap, flush and reset.
// A second instance with SPECIAL2 disabled shares the same stimulus.
module tb_decode_buffer;
    import decode_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_cnt;
    logic [63:0] in_instr;
    logic [63:0] in_pc;
    logic [1:0]  out_take;

    logic        in_ready,  in_ready0;
    logic [1:0]  out_valid, out_valid0;
    logic [63:0] out_instr, out_instr0;
    logic [63:0] out_pc,    out_pc0;
    op_t         out_op  [2];
    op_t         out_op0 [2];
    logic [1:0]  out_ri,    out_ri0;
    logic [3:0]  occ,       occ0;

    int n_chk  = 0;
    int n_fail = 0;
    int q[$];

    always #5 clk = ~clk;

    decode_buffer #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .EN_SPECIAL2(1)) u_dut (
        .clk(clk), .reset(rst), .flush(flush),
        .in_cnt(in_cnt), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_op(out_op), .out_ri(out_ri),
        .out_take(out_take), .occupancy(occ)
    );

    decode_buffer #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .EN_SPECIAL2(0)) u_dut0 (
        .clk(clk), .reset(rst), .flush(flush),
        .in_cnt(in_cnt), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_instr(out_instr0),
        .out_pc(out_pc0), .out_op(out_op0), .out_ri(out_ri0),
        .out_take(out_take), .occupancy(occ0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int c, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1, input int t);
        in_cnt   = 2'(c);
        in_instr = {i1, i0};
        in_pc    = {p1, p0};
        out_take = 2'(t);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        #12;
        n_chk++;
        if (occ !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ); end
        n_chk++;
        if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", out_valid); end
        n_chk++;
        if (out_ri !== 2'b00) begin n_fail++; $display("FAIL reset_ri: got %b want 00", out_ri); end
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        drv(2, 32'h00000000, 32'h100, 32'h24020005, 32'h104, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (out_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid: got %b want 11", out_valid); end
        n_chk++;
        if (out_op[0] !== NOP) begin n_fail++; $display("FAIL basic_op0: got %0d want %0d", out_op[0], NOP); end
        n_chk++;
        if (out_op[1] !== ADDIU) begin n_fail++; $display("FAIL basic_op1: got %0d want %0d", out_op[1], ADDIU); end
        n_chk++;
        if (out_ri !== 2'b00) begin n_fail++; $display("FAIL basic_ri: got %b want 00", out_ri); end
        n_chk++;
        if (occ !== 4'd2) begin n_fail++; $display("FAIL basic_occ: got %0d want 2", occ); end
        n_chk++;
        if (out_instr[63:32] !== 32'h24020005) begin
            n_fail++; $display("FAIL basic_instr1: got %h want 24020005", out_instr[63:32]);
        end
        n_chk++;
        if (out_pc !== {32'h104, 32'h100}) begin n_fail++; $display("FAIL basic_pc: got %h want 0000010400000100", out_pc); end
        drv(0, 0, 0, 0, 0, 2);
        tick();
        n_chk++;
        if (occ !== 4'd0 || out_valid !== 2'b00) begin
            n_fail++; $display("FAIL basic_drain: got occ %0d valid %b want 0 00", occ, out_valid);
        end
        tick();
        n_chk++;
        if (occ !== 4'd0) begin n_fail++; $display("FAIL empty_take: got occ %0d want 0", occ); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            drv(2, 32'h24020001, 32'h200 + 32'(8*k), 32'h24020002, 32'h204 + 32'(8*k), 0);
            tick();
            n_chk++;
            if (occ !== 4'(2*k+2)) begin n_fail++; $display("FAIL fill_occ%0d: got %0d want %0d", k, occ, 2*k+2); end
            n_chk++;
            if (in_ready !== (k < 3)) begin n_fail++; $display("FAIL fill_ready%0d: got %b want %b", k, in_ready, k < 3); end
        end
        drv(2, 32'h24020003, 32'h300, 32'h24020004, 32'h304, 0);
        tick();
        n_chk++;
        if (occ !== 4'd8) begin n_fail++; $display("FAIL full_drop: got occ %0d want 8", occ); end
        drv(2, 32'h24020003, 32'h300, 32'h24020004, 32'h304, 1);
        tick();
        n_chk++;
        if (occ !== 4'd7 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL occ7: got occ %0d ready %b want 7 0", occ, in_ready);
        end
        n_chk++;
        if (out_pc[31:0] !== 32'h204) begin n_fail++; $display("FAIL occ7_pc: got %h want 204", out_pc[31:0]); end
        drv(2, 32'h24020005, 32'h310, 32'h24020006, 32'h314, 2);
        tick();
        n_chk++;
        if (occ !== 4'd5) begin n_fail++; $display("FAIL no_free_space: got occ %0d want 5", occ); end
        n_chk++;
        if (out_pc[31:0] !== 32'h20c) begin n_fail++; $display("FAIL occ5_pc: got %h want 20c", out_pc[31:0]); end
        drv(2, 32'h24020007, 32'h320, 32'h24020008, 32'h324, 0);
        tick();
        n_chk++;
        if (occ !== 4'd7) begin n_fail++; $display("FAIL refill: got occ %0d want 7", occ); end
        drv(0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_decode();
        drv(1, 32'h70821002, 32'h400, 32'h0, 32'h0, 0);
        tick();
        n_chk++;
        if (out_op[0] !== MUL || out_ri[0] !== 1'b0) begin
            n_fail++; $display("FAIL mul_en: got op %0d ri %b want %0d 0", out_op[0], out_ri[0], MUL);
        end
        n_chk++;
        if (out_op0[0] !== DECODE_ERROR || out_ri0[0] !== 1'b1) begin
            n_fail++; $display("FAIL mul_dis: got op %0d ri %b want %0d 1", out_op0[0], out_ri0[0], DECODE_ERROR);
        end
        n_chk++;
        if (out_valid !== 2'b01) begin n_fail++; $display("FAIL mul_valid: got %b want 01", out_valid); end
        drv(2, 32'h98000000, 32'h404, 32'hfc000000, 32'h408, 1);
        tick();
        n_chk++;
        if (out_op[0] !== LWR) begin n_fail++; $display("FAIL lwr: got %0d want %0d", out_op[0], LWR); end
        n_chk++;
        if (out_op[1] !== DECODE_ERROR || out_ri !== 2'b10) begin
            n_fail++; $display("FAIL reserved: got op %0d ri %b want %0d 10", out_op[1], out_ri, DECODE_ERROR);
        end
        drv(2, 32'h42000018, 32'h40c, 32'h04110000, 32'h410, 2);
        tick();
        n_chk++;
        if (out_op[0] !== ERET || out_op[1] !== BGEZAL) begin
            n_fail++; $display("FAIL eret_bgezal: got %0d %0d want %0d %0d", out_op[0], out_op[1], ERET, BGEZAL);
        end
        n_chk++;
        if (out_ri !== 2'b00 || occ !== 4'd2) begin
            n_fail++; $display("FAIL eret_ri_occ: got %b %0d want 00 2", out_ri, occ);
        end
        drv(0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_wrap();
        int c;
        int t;
        int sz;
        logic [31:0] p0;
        logic [31:0] p1;
        q.delete();
        for (int s = 0; s < 21; s++) begin
            c  = (s == 0) ? 1 : 2;
            t  = (s == 0) ? 0 : ((s % 3 == 0) ? 1 : 2);
            p0 = 32'h1000 + 32'(8*s);
            p1 = p0 + 32'd4;
            drv(c, 32'h24020000, p0, 32'h24030000, p1, t);
            sz = q.size();
            for (int k = 0; k < t && k < sz; k++)
                void'(q.pop_front());
            if (8 - sz >= 2) begin
                q.push_back(int'(p0));
                if (c == 2)
                    q.push_back(int'(p1));
            end
            tick();
            n_chk++;
            if (occ !== 4'(q.size())) begin n_fail++; $display("FAIL wrap_occ%0d: got %0d want %0d", s, occ, q.size()); end
            if (q.size() > 0) begin
                n_chk++;
                if (out_pc[31:0] !== 32'(q[0])) begin
                    n_fail++; $display("FAIL wrap_pc0_%0d: got %h want %h", s, out_pc[31:0], q[0]);
                end
            end
            if (q.size() > 1) begin
                n_chk++;
                if (out_pc[63:32] !== 32'(q[1])) begin
                    n_fail++; $display("FAIL wrap_pc1_%0d: got %h want %h", s, out_pc[63:32], q[1]);
                end
            end
        end
        drv(2, 32'h24020000, 32'h2000, 32'h24030000, 32'h2004, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q.delete();
        n_chk++;
        if (occ !== 4'd0 || out_valid !== 2'b00) begin
            n_fail++; $display("FAIL flush: got occ %0d valid %b want 0 00", occ, out_valid);
        end
        drv(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        drv(2, 32'h0, 32'h500, 32'h0, 32'h504, 0);
        tick();
        tick();
        drv(1, 32'h0, 32'h510, 32'h0, 32'h514, 0);
        tick();
        n_chk++;
        if (occ !== 4'd5) begin n_fail++; $display("FAIL pre_reset_occ: got %0d want 5", occ); end
        drv(2, 32'h0, 32'h520, 32'h0, 32'h524, 0);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (occ !== 4'd0 || out_valid !== 2'b00) begin
            n_fail++; $display("FAIL async_reset: got occ %0d valid %b want 0 00", occ, out_valid);
        end
        tick();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (occ !== 4'd0 || out_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_write_lost: got occ %0d valid %b want 0 00", occ, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_decode();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
